// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single shared L2 port, one transaction at a time.
// Define CACHE_ARB_RR_EN for round-robin on simultaneous requests; otherwise D has fixed priority.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                l2_read_q, l2_read_d;
  logic                l2_write_q, l2_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                i_pend, d_pend, pick_d;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
`ifdef CACHE_ARB_RR_EN
    // On a tie the side that did not win last time goes next.
    pick_d = d_pend & (~i_pend | ~last_grant_q);
`else
    pick_d = d_pend;
`endif
    case (state_q)
      IDLE: begin
        if (i_pend | d_pend) begin
          state_d      = pick_d ? SERVE_D : SERVE_I;
          last_grant_d = pick_d;
          addr_d       = pick_d ? d_address : i_address;
          wdata_d      = d_wdata;
          // A writeback wins over a fill when the D-cache raises both.
          l2_write_d   = pick_d & d_write;
          l2_read_d    = ~(pick_d & d_write);
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d    = IDLE;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Completion is passed straight through in the L2 response cycle; IDLE masks stray responses.
  assign i_resp     = (state_q == SERVE_I) & l2_resp;
  assign d_resp     = (state_q == SERVE_D) & l2_resp;
  assign i_rdata    = i_resp ? l2_rdata : '0;
  assign d_rdata    = d_resp ? l2_rdata : '0;
  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_cache_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, l2_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, l2_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, l2_wdata;
  logic              i_resp, d_resp, l2_read, l2_write;
  logic [ADDR_W-1:0] l2_address;

  int n_cmp = 0;
  int n_fail = 0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir, dr, dw, rsp;
    logic e_rd, e_wr, e_ir, e_dr;
  } vec_t;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
  endtask

  localparam logic [LINE_W-1:0] A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] W1 = {8{32'h12345678}};

  vec_t tbl[11];
  int   exp_order[4];
  int   got;

  // reference model state
  bit              m_busy, m_own, m_wr, m_last, i_want, d_want, win_d;
  logic [ADDR_W-1:0] m_addr, ia, da;
  logic [LINE_W-1:0] m_wdata;
  logic [1:0]      dop;

  initial begin
    tbl[0]  = '{0,0,0,0, 0,0,0,0};
    tbl[1]  = '{1,0,0,0, 0,0,0,0};
    tbl[2]  = '{1,0,0,0, 1,0,0,0};
    tbl[3]  = '{1,0,0,0, 1,0,0,0};
    tbl[4]  = '{1,0,0,1, 1,0,1,0};
    tbl[5]  = '{0,0,0,0, 0,0,0,0};
    tbl[6]  = '{0,0,0,1, 0,0,0,0};
    tbl[7]  = '{0,1,1,0, 0,0,0,0};
    tbl[8]  = '{0,1,1,0, 0,1,0,0};
    tbl[9]  = '{0,1,1,1, 0,1,0,1};
    tbl[10] = '{0,0,0,0, 0,0,0,0};

    // Reset with requests and a response present: everything must read zero.
    rst = 1'b1;
    i_read = 1; d_read = 1; d_write = 1; l2_resp = 1;
    i_address = 32'h1000; d_address = 32'h2000; d_wdata = W1; l2_rdata = A5;
    #4;
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_write", l2_write, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_l2_addr", l2_address, 0);
    chk("rst_l2_wdata", l2_wdata, 0);
    tick(); tick();
    rst = 1'b0;
    idle_inputs();

    foreach (tbl[k]) begin
      tick();
      i_read = tbl[k].ir; d_read = tbl[k].dr; d_write = tbl[k].dw; l2_resp = tbl[k].rsp;
      #3;
      chk($sformatf("tbl%0d_l2_read", k), l2_read, tbl[k].e_rd);
      chk($sformatf("tbl%0d_l2_write", k), l2_write, tbl[k].e_wr);
      chk($sformatf("tbl%0d_i_resp", k), i_resp, tbl[k].e_ir);
      chk($sformatf("tbl%0d_d_resp", k), d_resp, tbl[k].e_dr);
      chk($sformatf("tbl%0d_i_rdata", k), i_rdata, tbl[k].e_ir ? A5 : '0);
      chk($sformatf("tbl%0d_d_rdata", k), d_rdata, tbl[k].e_dr ? A5 : '0);
      if (tbl[k].e_rd) chk($sformatf("tbl%0d_l2_addr", k), l2_address, 32'h1000);
      if (tbl[k].e_wr) chk($sformatf("tbl%0d_l2_wdata", k), l2_wdata, W1);
    end

    // Writeback: d_wdata changes after grant, L2 must still see the latched line.
    tick(); d_write = 1; d_address = 32'h2000; d_wdata = W1;
    #3; chk("wb_not_yet", l2_write, 0);
    tick(); d_wdata = ~W1; d_address = 32'h3000;
    #3; chk("wb_l2_write", l2_write, 1); chk("wb_wdata", l2_wdata, W1); chk("wb_addr", l2_address, 32'h2000);
    chk("wb_no_resp", d_resp, 0);
    tick(); l2_resp = 1;
    #3; chk("wb_d_resp", d_resp, 1); chk("wb_wdata_hold", l2_wdata, W1); chk("wb_i_resp", i_resp, 0);
    tick(); idle_inputs();
    #3; chk("wb_done", l2_write, 0); chk("wb_d_resp_done", d_resp, 0);

    // Both sides requesting continuously for four transactions.
`ifdef CACHE_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    do_reset();
    for (int t = 0; t < 4; t++) begin
      got = -1;
      for (int c = 0; c < 16 && got < 0; c++) begin
        tick();
        i_read = 1; d_read = 1; d_write = 0;
        l2_resp = l2_read | l2_write;
        #3;
        if (i_resp) got = 0;
        else if (d_resp) got = 1;
      end
      chk($sformatf("tie_grant%0d", t), got, exp_order[t]);
    end
    tick(); idle_inputs();

    // Reset in SERVE_D before the response, then a stray response in IDLE.
    do_reset();
    tick(); d_read = 1; d_address = 32'h4000;
    got = -1;
    for (int c = 0; c < 8 && got < 0; c++) begin
      tick();
      #3;
      if (l2_read) got = 1;
    end
    chk("ar_served", got, 1);
    rst = 1'b1;
    #1;
    chk("ar_l2_read_async", l2_read, 0);
    chk("ar_d_resp", d_resp, 0);
    tick(); rst = 1'b0; d_read = 0;
    tick(); l2_resp = 1;
    #3; chk("ar_stray_d_resp", d_resp, 0); chk("ar_stray_l2_read", l2_read, 0);
    tick(); l2_resp = 0;
    #3; chk("ar_idle_l2_read", l2_read, 0); chk("ar_idle_l2_write", l2_write, 0);

    // Randomized protocol-following traffic against the reference model.
    do_reset();
    m_busy = 0; m_own = 0; m_wr = 0; m_last = 1; m_addr = '0; m_wdata = '0;
    i_want = 0; d_want = 0; ia = '0; da = '0; dop = 2'b01;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (!i_want && $urandom_range(0, 1) == 1) begin i_want = 1; ia = $urandom; end
      if (!d_want && $urandom_range(0, 1) == 1) begin
        d_want = 1; da = $urandom; dop = 2'($urandom_range(1, 3));
      end
      i_read = i_want; i_address = ia;
      d_read = d_want & dop[0]; d_write = d_want & dop[1]; d_address = da;
      d_wdata = {8{$urandom}};
      l2_rdata = {8{$urandom}};
      l2_resp = ($urandom_range(0, 2) == 0);
      #3;
      chk("rnd_l2_read", l2_read, m_busy & ~m_wr);
      chk("rnd_l2_write", l2_write, m_busy & m_wr);
      chk("rnd_i_resp", i_resp, m_busy & ~m_own & l2_resp);
      chk("rnd_d_resp", d_resp, m_busy & m_own & l2_resp);
      chk("rnd_i_rdata", i_rdata, (m_busy & ~m_own & l2_resp) ? l2_rdata : '0);
      chk("rnd_d_rdata", d_rdata, (m_busy & m_own & l2_resp) ? l2_rdata : '0);
      if (m_busy) chk("rnd_l2_addr", l2_address, m_addr);
      if (m_busy && m_wr) chk("rnd_l2_wdata", l2_wdata, m_wdata);
      // advance the model across the coming clock edge
      if (m_busy) begin
        if (l2_resp) begin
          m_busy = 0;
          if (m_own) d_want = 0; else i_want = 0;
        end
      end else if (i_read || d_read || d_write) begin
        if (i_read && (d_read || d_write)) begin
`ifdef CACHE_ARB_RR_EN
          win_d = ~m_last;
`else
          win_d = 1;
`endif
        end else begin
          win_d = d_read | d_write;
        end
        m_busy = 1; m_own = win_d; m_last = win_d;
        m_wr = win_d & d_write;
        m_addr = win_d ? d_address : i_address;
        m_wdata = d_wdata;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 The block SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-003 The block SHALL have one clock, clk (input, 1), rising-edge active.
REQ-004 The block SHALL have rst (input, 1), reset, asynchronous and active-high.
REQ-005 The block SHALL have i_read (input, 1), an I-cache line fill request held until i_resp.
REQ-006 The block SHALL have i_address (input, ADDR_W), the I-cache line address.
REQ-007 The block SHALL have i_rdata (output, LINE_W), the fill data to the I-cache.
REQ-008 The block SHALL have i_resp (output, 1), a one-cycle I-cache completion pulse.
REQ-009 The block SHALL have d_read and d_write (inputs, 1 each), D-cache fill and writeback requests held until d_resp.
REQ-010 The block SHALL have d_address (input, ADDR_W), the D-cache line address.
REQ-011 The block SHALL have d_wdata (input, LINE_W), the D-cache writeback line.
REQ-012 The block SHALL have d_rdata (output, LINE_W), the fill data to the D-cache.
REQ-013 The block SHALL have d_resp (output, 1), a one-cycle D-cache completion pulse.
REQ-014 The block SHALL have l2_read and l2_write (outputs, 1 each), requests to the shared L2.
REQ-015 The block SHALL have l2_address (output, ADDR_W) and l2_wdata (output, LINE_W), both to the L2.
REQ-016 The block SHALL have l2_rdata (input, LINE_W) and l2_resp (input, 1), from the L2.

Function
REQ-017 The FSM SHALL have the states IDLE, SERVE_I and SERVE_D, and one transaction SHALL be outstanding at the L2 at a time.
REQ-018 In IDLE, a pending request (i_read, or d_read|d_write) SHALL be granted at the clock edge, with the next state SERVE_I or SERVE_D.
REQ-019 On grant, the block SHALL latch the address, the operation (d_write takes precedence if both d_read and d_write are high) and d_wdata into registers.
REQ-020 l2_read, l2_write, l2_address and l2_wdata SHALL be driven only from the latched registers, so l2_read or l2_write rises on the cycle after the request is first seen in IDLE.
REQ-021 In SERVE_x, l2_read or l2_write SHALL stay high until the cycle in which l2_resp is high.
REQ-022 When l2_resp is high in SERVE_x, x_resp SHALL be high in that same cycle, with x_rdata = l2_rdata; the next state SHALL be IDLE.
REQ-023 When not granted, i_rdata and d_rdata SHALL be 0, and i_resp and d_resp SHALL be 0.
REQ-024 l2_resp received while in IDLE SHALL be ignored.
REQ-025 If a requester drops its request while granted, the L2 transaction SHALL still complete and the response pulse SHALL still go to the latched owner.
REQ-026 Requesters SHALL drop or re-present their request in the cycle after x_resp; a request seen in IDLE is a new request.
REQ-027 Minimum turnaround SHALL be 1 IDLE cycle between transactions.
REQ-028 A 1-bit register last_grant (0 = I, 1 = D) SHALL update on every grant.

Reset
REQ-029 On rst assertion, the block SHALL go to IDLE asynchronously, with last_grant = 1 (I-cache wins the first tie).
REQ-030 During reset, the block SHALL drive all outputs to 0, and all latched registers SHALL be 0.
REQ-031 If reset is asserted mid-transaction, the transaction SHALL be abandoned with no x_resp, and any later l2_resp SHALL be ignored per REQ-024.

Configuration
REQ-032 With CACHE_ARB_RR_EN defined, simultaneous I and D requests in IDLE SHALL be granted to the requester that is not last_grant (round-robin).
REQ-033 Without CACHE_ARB_RR_EN, simultaneous requests SHALL always be granted to D (fixed priority), with last_grant still updated but unused.

Verification
REQ-034 Scenario: reset, then i_read=1 with i_address=0x0000_1000; L2 responds 3 cycles later with l2_rdata=0xA5..A5 -> l2_read rises 1 cycle after i_read, l2_address=0x1000, i_resp is a single pulse with i_rdata=0xA5..A5, and d_resp stays 0.
REQ-035 Scenario: d_write=1 with d_address=0x2000 and d_wdata=0x1234..; d_wdata changes after the grant -> l2_write=1, l2_wdata holds the latched 0x1234.., and d_resp pulses with l2_resp.
REQ-036 Scenario: i_read and d_read held together for 4 transactions, with CACHE_ARB_RR_EN defined -> grant order I, D, I, D.
REQ-037 Scenario: the same stimulus without CACHE_ARB_RR_EN -> grant order D, D, D, D while D keeps requesting.
REQ-038 Scenario: rst pulsed in SERVE_D before l2_resp, then l2_resp=1 in IDLE -> no d_resp, l2_read/l2_write drop asynchronously, and the state stays IDLE.
REQ-039 Scenario: d_read and d_write both 1 -> l2_write=1 and l2_read=0.
